// File: rtl/gsensor_filter_if.sv
// rtl/gsensor_filter_if.sv - signal bundle between the raw sensor source and gsensor_filter
//
// Purpose: groups the control, raw input and filtered output signals of the
//          sensor conditioning stage so they travel as one port.
// Signals:
//   Enable     source -> filter  1 = filter runs, 0 = output frozen
//   RawSensor  source -> filter  asynchronous raw reporter/sensor level
//   GlitchClr  source -> filter  synchronous clear of GlitchCnt
//   Sensor     filter -> source  filtered level (feeds the C-element Sensor input)
//   Changed    filter -> source  one-cycle pulse on the cycle Sensor toggles
//   GlitchCnt  filter -> source  saturating count of aborted transitions
// Modports:
//   master  drives Enable/RawSensor/GlitchClr (stimulus side)
//   slave   the filter itself

interface gsensor_filter_if;
  logic       Enable;
  logic       RawSensor;
  logic       GlitchClr;
  logic       Sensor;
  logic       Changed;
  logic [7:0] GlitchCnt;

  modport master (
    output Enable,
    output RawSensor,
    output GlitchClr,
    input  Sensor,
    input  Changed,
    input  GlitchCnt
  );

  modport slave (
    input  Enable,
    input  RawSensor,
    input  GlitchClr,
    output Sensor,
    output Changed,
    output GlitchCnt
  );
endinterface

// File: rtl/gsensor_filter.sv
// rtl/gsensor_filter.sv - synchroniser and rise/fall debouncer ahead of the genetic C-element gate
//
// Purpose: brings the asynchronous raw sensor level into the clk domain,
//          then only lets the filtered Sensor level change after HIGH_COUNT
//          consecutive 1 samples (rise) or LOW_COUNT consecutive 0 samples
//          (fall). Aborted transitions are counted as glitches.
// Parameters:
//   SYNC_STAGES  flip-flop stages on RawSensor (>= 2)
//   HIGH_COUNT   consecutive synced 1 samples needed to assert Sensor (1..255)
//   LOW_COUNT    consecutive synced 0 samples needed to deassert Sensor (1..255)
// Ports:
//   clk  in   sole clock, rising edge
//   rst  in   synchronous, active-high reset
//   bus  slave modport of gsensor_filter_if (Enable, RawSensor, GlitchClr in;
//        Sensor, Changed, GlitchCnt out, all outputs registered)

module gsensor_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int HIGH_COUNT  = 8,
  parameter int LOW_COUNT   = 8
) (
  input  logic            clk,
  input  logic            rst,
  gsensor_filter_if.slave bus
);

  localparam int MAX_COUNT = (HIGH_COUNT > LOW_COUNT) ? HIGH_COUNT : LOW_COUNT;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  // Counter value on the sample that completes a transition: the first
  // sample of a run is taken on the LOW->RISING / HIGH->FALLING edge.
  localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_COUNT - 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_COUNT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // A threshold of one skips the intermediate state entirely.
  localparam bit RISE_DIRECT = (HIGH_COUNT == 1);
  localparam bit FALL_DIRECT = (LOW_COUNT == 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISING,
    ST_HIGH,
    ST_FALLING
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   sensor_q;
  logic                   changed_q;
  logic [7:0]             glitch_cnt_q;
  logic [7:0]             glitch_cnt_d;
  logic                   glitch_d;

  // Synchroniser: bit 0 samples the raw level, the top bit is the only
  // value the FSM ever looks at.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.RawSensor};
  assign s      = sync_q[SYNC_STAGES-1];

  // A glitch is a pending transition that sees the old level again while
  // enabled. Dropping Enable cancels a transition without counting it.
  always_comb begin
    glitch_d = 1'b0;
    if (bus.Enable) begin
      glitch_d = ((state_q == ST_RISING) && !s) ||
                 ((state_q == ST_FALLING) && s);
    end
  end

  // Clear takes priority over a glitch on the same edge; the count sticks
  // at 255 instead of wrapping.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (bus.GlitchClr) begin
      glitch_cnt_d = 8'd0;
    end else if (glitch_d && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= ST_LOW;
      cnt_q        <= CNT_ZERO;
      sensor_q     <= 1'b0;
      changed_q    <= 1'b0;
      glitch_cnt_q <= 8'd0;
    end else begin
      sync_q       <= sync_d;
      glitch_cnt_q <= glitch_cnt_d;
      changed_q    <= 1'b0;

      if (!bus.Enable) begin
        // Frozen: abandon any pending transition, keep Sensor as it is.
        case (state_q)
          ST_RISING: begin
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
          end
          ST_FALLING: begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_ZERO;
          end
          default: begin
            cnt_q <= CNT_ZERO;
          end
        endcase
      end else begin
        case (state_q)
          ST_LOW: begin
            cnt_q <= CNT_ZERO;
            if (s) begin
              if (RISE_DIRECT) begin
                state_q   <= ST_HIGH;
                sensor_q  <= 1'b1;
                changed_q <= 1'b1;
              end else begin
                state_q <= ST_RISING;
                cnt_q   <= CNT_ONE;
              end
            end
          end

          ST_RISING: begin
            if (!s) begin
              state_q <= ST_LOW;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_q == HIGH_LAST) begin
              state_q   <= ST_HIGH;
              cnt_q     <= CNT_ZERO;
              sensor_q  <= 1'b1;
              changed_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          ST_HIGH: begin
            cnt_q <= CNT_ZERO;
            if (!s) begin
              if (FALL_DIRECT) begin
                state_q   <= ST_LOW;
                sensor_q  <= 1'b0;
                changed_q <= 1'b1;
              end else begin
                state_q <= ST_FALLING;
                cnt_q   <= CNT_ONE;
              end
            end
          end

          ST_FALLING: begin
            if (s) begin
              state_q <= ST_HIGH;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_q == LOW_LAST) begin
              state_q   <= ST_LOW;
              cnt_q     <= CNT_ZERO;
              sensor_q  <= 1'b0;
              changed_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end

          default: begin
            state_q  <= ST_LOW;
            cnt_q    <= CNT_ZERO;
            sensor_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Sensor    = sensor_q;
  assign bus.Changed   = changed_q;
  assign bus.GlitchCnt = glitch_cnt_q;

endmodule
